// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: op codes,
// FSM state encoding, datapath defaults and the latched-instruction record.
package alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    localparam int AW        = 3;

    localparam logic [3:0] OP_SUB    = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_OR     = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_DEC    = 4'd4;
    localparam logic [3:0] OP_INC    = 4'd5;
    localparam logic [3:0] OP_INVERT = 4'd6;
    localparam logic [3:0] OP_LSL    = 4'd8;
    localparam logic [3:0] OP_SLT    = 4'd9;
    localparam logic [3:0] OP_LSR    = 4'd10;
    localparam logic [3:0] OP_ASL    = 4'd12;
    localparam logic [3:0] OP_ASR    = 4'd14;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_OPERAND   = 2'd1;
    localparam logic [1:0] ST_EXECUTE   = 2'd2;
    localparam logic [1:0] ST_WRITEBACK = 2'd3;

    typedef struct packed {
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          imm_sel;
    } instr_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_SUB, OP_ADD, OP_OR, OP_AND, OP_DEC, OP_INC, OP_INVERT,
            OP_LSL, OP_SLT, OP_LSR, OP_ASL, OP_ASR: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file: two combinational read ports, a debug read port and one
// synchronous write port. r0 is hardwired to zero on every read port.
module regfile_8x16
    import alu_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] regs [NREGS];

    // NOTE: the array sits in the reset branch because the architecture
    // requires every register to read 0 after reset; a plain RAM macro
    // would not offer that, so this must stay a flop array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue/writeback controller in front of the 16-bit ALU:
// accept -> read operands -> let ALU settle -> write back and update flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [2:0]       in_rd,
    input  logic [2:0]       in_rs,
    input  logic [2:0]       in_rt,
    input  logic             in_imm_sel,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_ovf,
    input  logic             alu_zero,
    output logic             done,
    output logic             illegal,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_v_sticky,
    input  logic             v_clr,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [1:0]       state;
    logic             run_q;
    instr_t           instr_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] res_s;
    logic             res_ovf;
    logic             res_zero;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             op_legal;
    logic             wb_legal;

    regfile_8x16 #(.NREGS(NREGS), .WIDTH(WIDTH)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (instr_q.rs),
        .ra_data  (rs_data),
        .rb_addr  (instr_q.rt),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_legal),
        .wa       (instr_q.rd),
        .wd       (res_s)
    );

    assign op_legal = is_legal_op(instr_q.op);
    assign wb_legal = (state == ST_WRITEBACK) && op_legal;
    assign done     = (state == ST_WRITEBACK);
    assign illegal  = done && !op_legal;
    // run_q keeps in_ready low until the first clock after reset release.
    assign in_ready = run_q && (state == ST_IDLE);

    // NOTE: all state below uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            run_q    <= 1'b0;
            instr_q  <= '0;
            imm_q    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            res_s    <= '0;
            res_ovf  <= 1'b0;
            res_zero <= 1'b0;
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        instr_q <= '{op: in_op, rd: in_rd, rs: in_rs,
                                     rt: in_rt, imm_sel: in_imm_sel};
                        imm_q   <= in_imm;
                        state   <= ST_OPERAND;
                    end
                end
                ST_OPERAND: begin
                    alu_a    <= rs_data;
                    alu_b    <= instr_q.imm_sel ? imm_q : rt_data;
                    alu_ctrl <= instr_q.op;
                    state    <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    res_s    <= alu_s;
                    res_ovf  <= alu_ovf;
                    res_zero <= alu_zero;
                    state    <= ST_WRITEBACK;
                end
                default: begin
                    if (op_legal) begin
                        flag_z <= res_zero;
                        flag_v <= res_ovf;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A writeback that sets overflow takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_v_sticky <= 1'b0;
        end else if (wb_legal && res_ovf) begin
            flag_v_sticky <= 1'b1;
        end else if (v_clr) begin
            flag_v_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed-vector bench for alu_issue_ctrl with a behavioural ALU stand-in;
// stimulus pushes hand-computed expectations, a monitor pops them on done.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs;
    logic [2:0]  in_rt;
    logic        in_imm_sel;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_s;
    logic        alu_ovf;
    logic        alu_zero;
    logic        done;
    logic        illegal;
    logic        flag_z;
    logic        flag_v;
    logic        flag_v_sticky;
    logic        v_clr;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    logic        mon_sel;
    logic [2:0]  mon_addr;
    logic [2:0]  stim_addr;
    assign dbg_addr = mon_sel ? mon_addr : stim_addr;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] val;
        logic        z;
        logic        v;
        logic        st;
        logic        ill;
        int          hs;
    } exp_t;

    exp_t sb[$];

    alu_issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rd         (in_rd),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_imm_sel    (in_imm_sel),
        .in_imm        (in_imm),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .alu_s         (alu_s),
        .alu_ovf       (alu_ovf),
        .alu_zero      (alu_zero),
        .done          (done),
        .illegal       (illegal),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_v_sticky (flag_v_sticky),
        .v_clr         (v_clr),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; unused codes drive a poison result so a wrongly
    // retired illegal op shows up in the register or flags.
    always_comb begin
        alu_s   = 16'hDEAD;
        alu_ovf = 1'b1;
        case (alu_ctrl)
            4'd0: begin
                alu_s   = alu_a - alu_b;
                alu_ovf = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'd1: begin
                alu_s   = alu_a + alu_b;
                alu_ovf = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            4'd2:  begin alu_s = alu_a | alu_b; alu_ovf = 1'b0; end
            4'd3:  begin alu_s = alu_a & alu_b; alu_ovf = 1'b0; end
            4'd4:  begin alu_s = alu_a - 16'd1; alu_ovf = (alu_a == 16'h8000); end
            4'd5:  begin alu_s = alu_a + 16'd1; alu_ovf = (alu_a == 16'h7FFF); end
            4'd6:  begin alu_s = ~alu_a; alu_ovf = 1'b0; end
            4'd8:  begin alu_s = alu_a << alu_b[3:0]; alu_ovf = 1'b0; end
            4'd9:  begin alu_s = {15'd0, $signed(alu_a) < $signed(alu_b)}; alu_ovf = 1'b0; end
            4'd10: begin alu_s = alu_a >> alu_b[3:0]; alu_ovf = 1'b0; end
            4'd12: begin alu_s = alu_a << alu_b[3:0]; alu_ovf = 1'b0; end
            4'd14: begin alu_s = $unsigned($signed(alu_a) >>> alu_b[3:0]); alu_ovf = 1'b0; end
            default: ;
        endcase
        alu_zero = (alu_s == 16'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Offers one instruction, waits (bounded) for acceptance and, when a
    // retire is expected, pushes the hand-computed outcome for the monitor.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic sel, input logic [15:0] imm,
                         input logic expect_done, input logic [15:0] val, input logic z,
                         input logic v, input logic st, input logic ill, input logic keep,
                         output int hs, output int waits);
        exp_t e;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_imm_sel = sel; in_imm = imm; in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            hs = -1;
            return;
        end
        hs = cyc + 1;
        if (expect_done) begin
            e.op = op; e.rd = rd; e.val = val; e.z = z; e.v = v;
            e.st = st; e.ill = ill; e.hs = hs;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // Monitor: on each done, compare the retire against the oldest
    // expectation, then read the destination one cycle later.
    initial begin
        exp_t e;
        mon_sel  = 1'b0;
        mon_addr = 3'd0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.op});
                    // done is consumed by the third edge after the handshake edge
                    check("retire_latency", cyc + 1 - e.hs, 32'd3);
                    mon_sel  = 1'b1;
                    mon_addr = e.rd;
                    @(negedge clk);
                    check("reg_value", {16'd0, dbg_data}, {16'd0, e.val});
                    check("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                    check("flag_v", {31'd0, flag_v}, {31'd0, e.v});
                    check("flag_v_sticky", {31'd0, flag_v_sticky}, {31'd0, e.st});
                    mon_sel = 1'b0;
                end
            end
        end
    end

    initial begin
        int hs_a, hs_b, w;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0;
        in_rt = '0; in_imm_sel = 1'b0; in_imm = '0; v_clr = 1'b0; stim_addr = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_flags", {29'd0, flag_z, flag_v, flag_v_sticky}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_pre", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        //      op    rd    rs    rt    sel   imm        exp val    z     v     st    ill   keep
        issue(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hs_a, w);
        wait_idle();
        issue(4'd5, 3'd2, 3'd1, 3'd0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, hs_a, w);
        wait_idle();
        v_clr = 1'b1;
        @(negedge clk);
        v_clr = 1'b0;
        check("v_clr_sticky", {31'd0, flag_v_sticky}, 32'd0);
        check("v_clr_keeps_flag_v", {31'd0, flag_v}, 32'd1);

        issue(4'd0, 3'd3, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, hs_a, w);
        wait_idle();
        // unused op: no write to r5, flags keep the sub result
        issue(4'd7, 3'd5, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, hs_a, w);
        wait_idle();
        issue(4'd2, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0100, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hs_a, w);
        wait_idle();
        // overflow at writeback beats a v_clr held through the same edge
        v_clr = 1'b1;
        issue(4'd5, 3'd7, 3'd1, 3'd0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, hs_a, w);
        wait_idle();
        v_clr = 1'b0;

        // back-to-back with in_valid held: r0 write dropped, then r5 = r2 | r4
        issue(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, hs_a, w);
        issue(4'd2, 3'd5, 3'd2, 3'd4, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, hs_b, w);
        check("busy_cycles_in_ready_low", w, 32'd3);
        check("b2b_handshake_spacing", hs_b - hs_a, 32'd4);
        wait_idle();

        // reset during EXECUTE discards the instruction
        issue(4'd1, 3'd6, 3'd0, 3'd0, 1'b1, 16'h00AA, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hs_a, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_release_in_ready_pre", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_release_in_ready", {31'd0, in_ready}, 32'd1);
        stim_addr = 3'd6;
        #1;
        check("r6_after_reset", {16'd0, dbg_data}, 32'd0);
        stim_addr = 3'd1;
        #1;
        check("r1_after_reset", {16'd0, dbg_data}, 32'd0);
        check("alu_b_after_reset", {16'd0, alu_b}, 32'd0);
        check("alu_ctrl_after_reset", {28'd0, alu_ctrl}, 32'd0);
        check("flags_after_reset", {29'd0, flag_z, flag_v, flag_v_sticky}, 32'd0);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("scoreboard_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
